// File: rtl/cmp_iter.sv
// Multi-cycle MSB-first magnitude comparator with valid/ready request and result ports.
// Optional min/max result outputs are enabled by defining CMP_MINMAX_EN.
module cmp_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             equal_o,
    output logic             alarger_o,
`ifdef CMP_MINMAX_EN
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o,
`endif
    output logic             blarger_o
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               eq_q, eq_d, agt_q, agt_d, bgt_q, bgt_d;
`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0]   ao_q, ao_d, bo_q, bo_d;
    logic [WIDTH-1:0]   min_q, min_d, max_q, max_d;
`endif

    logic [CHUNK-1:0]   a_sl [N];
    logic [CHUNK-1:0]   b_sl [N];
    logic [CHUNK-1:0]   a_cur, b_cur;
    logic               accept;

    // Slice view of the biased operands
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign a_sl[g] = a_q[g*CHUNK +: CHUNK];
        assign b_sl[g] = b_q[g*CHUNK +: CHUNK];
    end

    assign a_cur   = a_sl[idx_q];
    assign b_cur   = b_sl[idx_q];
    assign ready_o = rst_ni && ((state_q == IDLE) || ((state_q == DONE) && ready_i));
    assign accept  = valid_i && ready_o;

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        eq_d    = eq_q;
        agt_d   = agt_q;
        bgt_d   = bgt_q;
`ifdef CMP_MINMAX_EN
        ao_d    = ao_q;
        bo_d    = bo_q;
        min_d   = min_q;
        max_d   = max_q;
`endif
        case (state_q)
            IDLE: ;
            BUSY: begin
                if (a_cur != b_cur) begin
                    agt_d   = (a_cur > b_cur);
                    bgt_d   = (a_cur < b_cur);
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef CMP_MINMAX_EN
                    min_d   = (a_cur > b_cur) ? bo_q : ao_q;
                    max_d   = (a_cur > b_cur) ? ao_q : bo_q;
`endif
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef CMP_MINMAX_EN
                    min_d   = ao_q;
                    max_d   = ao_q;
`endif
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    eq_d    = 1'b0;
                    agt_d   = 1'b0;
                    bgt_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Request load, from IDLE or chained out of DONE
        if (accept) begin
            a_d     = signed_i ? (a_i ^ MSB_MASK) : a_i;
            b_d     = signed_i ? (b_i ^ MSB_MASK) : b_i;
            idx_d   = IDX_W'(N - 1);
            state_d = BUSY;
`ifdef CMP_MINMAX_EN
            ao_d    = a_i;
            bo_d    = b_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
            agt_q   <= 1'b0;
            bgt_q   <= 1'b0;
`ifdef CMP_MINMAX_EN
            ao_q    <= '0;
            bo_q    <= '0;
            min_q   <= '0;
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            eq_q    <= eq_d;
            agt_q   <= agt_d;
            bgt_q   <= bgt_d;
`ifdef CMP_MINMAX_EN
            ao_q    <= ao_d;
            bo_q    <= bo_d;
            min_q   <= min_d;
            max_q   <= max_d;
`endif
        end
    end

    assign valid_o   = valid_q;
    assign equal_o   = eq_q;
    assign alarger_o = agt_q;
    assign blarger_o = bgt_q;
`ifdef CMP_MINMAX_EN
    assign min_o     = min_q;
    assign max_o     = max_q;
`endif

endmodule

// File: tb/tb_cmp_iter.sv
// Randomised self-checking bench for cmp_iter (WIDTH=32, CHUNK=8); honours CMP_MINMAX_EN.
module tb_cmp_iter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             valid_i, ready_o, signed_i, valid_o, ready_i;
    logic [WIDTH-1:0] a_i, b_i;
    logic             equal_o, alarger_o, blarger_o;
`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] min_o, max_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .valid_o(valid_o),
        .ready_i(ready_i), .equal_o(equal_o), .alarger_o(alarger_o),
`ifdef CMP_MINMAX_EN
        .min_o(min_o), .max_o(max_o),
`endif
        .blarger_o(blarger_o)
    );

    // Reference: {equal, a larger, b larger} from plain integer comparison
    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (a == b) return 3'b100;
        if (s) return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
        return (a > b) ? 3'b010 : 3'b001;
    endfunction

    // Reference: chunks examined = first differing chunk from the MSB, else N
    function automatic int ref_k(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        x = a ^ b;
        for (int i = 0; i < int'(N); i++)
            if (((x >> (WIDTH - CHUNK * (i + 1))) & 32'hFF) != 0) return i + 1;
        return N;
    endfunction

    function automatic logic [31:0] ref_min(input logic [31:0] a, input logic [31:0] b, input logic s);
        return (ref_flags(a, b, s) == 3'b010) ? b : a;
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b, input logic s);
        return (ref_flags(a, b, s) == 3'b001) ? b : a;
    endfunction

    // Stimulus only: issue one request from IDLE and count cycles until valid_o
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int k, output bit rdy_busy);
        valid_i = 1'b1; a_i = a; b_i = b; signed_i = s;
        @(posedge clk); #1;
        valid_i = 1'b0; a_i = $urandom; b_i = $urandom; signed_i = $urandom_range(0, 1);
        k = 0; rdy_busy = 1'b0;
        while (valid_o !== 1'b1 && k < 20) begin
            if (ready_o !== 1'b0) rdy_busy = 1'b1;
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic retire();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({valid_o, equal_o, alarger_o, blarger_o, ready_o} !== 5'b0) begin
            fails++; $display("FAIL reset_outputs got=%b want=00000", {valid_o, equal_o, alarger_o, blarger_o, ready_o});
        end
        rst_ni = 1'b1; #1;
        tests++;
        if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    endtask

    task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
        int k; bit rb;
        send(a, b, s, k, rb);
        tests++;
        if (k != ref_k(a, b)) begin fails++; $display("FAIL %s_latency got=%0d want=%0d", name, k, ref_k(a, b)); end
        tests++;
        if ({equal_o, alarger_o, blarger_o} !== ref_flags(a, b, s)) begin
            fails++; $display("FAIL %s_flags got=%b want=%b", name, {equal_o, alarger_o, blarger_o}, ref_flags(a, b, s));
        end
        tests++;
        if (rb) begin fails++; $display("FAIL %s_busy_ready got=1 want=0", name); end
`ifdef CMP_MINMAX_EN
        tests++;
        if (min_o !== ref_min(a, b, s) || max_o !== ref_max(a, b, s)) begin
            fails++; $display("FAIL %s_minmax got=%h/%h want=%h/%h", name, min_o, max_o, ref_min(a, b, s), ref_max(a, b, s));
        end
`endif
        retire();
        tests++;
        if ({valid_o, equal_o, alarger_o, blarger_o} !== 4'b0) begin
            fails++; $display("FAIL %s_retire got=%b want=0000", name, {valid_o, equal_o, alarger_o, blarger_o});
        end
    endtask

    task automatic test_hold();
        int k; bit rb; logic [2:0] f0;
        send(32'h1234_5678, 32'h1234_5679, 1'b0, k, rb);
        f0 = {equal_o, alarger_o, blarger_o};
        tests++;
        if (k != 4 || f0 !== 3'b001 || rb) begin
            fails++; $display("FAIL hold_first got k=%0d f=%b rb=%b want k=4 f=001 rb=0", k, f0, rb);
        end
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            @(posedge clk); #1;
            tests++;
            if (valid_o !== 1'b1 || {equal_o, alarger_o, blarger_o} !== f0 || ready_o !== 1'b0) begin
                fails++; $display("FAIL hold_stable cyc=%0d got v=%b f=%b r=%b want v=1 f=%b r=0",
                                  i, valid_o, {equal_o, alarger_o, blarger_o}, ready_o, f0);
            end
        end
        valid_i = 1'b0;
        retire();
    endtask

    task automatic test_back_to_back();
        int k; bit rb;
        send(32'hFF00_0000, 32'h0100_0000, 1'b0, k, rb);
        ready_i = 1'b1; valid_i = 1'b1; a_i = 32'd5; b_i = 32'd5; signed_i = 1'b0;
        #1;
        tests++;
        if (ready_o !== 1'b1) begin fails++; $display("FAIL chain_ready got=%b want=1", ready_o); end
        @(posedge clk); #1;
        ready_i = 1'b0; valid_i = 1'b0; a_i = $urandom; b_i = $urandom;
        tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
            fails++; $display("FAIL chain_accept got v=%b r=%b want v=0 r=0", valid_o, ready_o);
        end
        k = 0;
        while (valid_o !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        tests++;
        if (k != 4 || {equal_o, alarger_o, blarger_o} !== 3'b100) begin
            fails++; $display("FAIL chain_result got k=%0d f=%b want k=4 f=100", k, {equal_o, alarger_o, blarger_o});
        end
        retire();
    endtask

    task automatic test_reset_mid_busy();
        valid_i = 1'b1; a_i = 32'hDEAD_BEEF; b_i = 32'hDEAD_BEEF; signed_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({valid_o, equal_o, alarger_o, blarger_o, ready_o} !== 5'b0) begin
            fails++; $display("FAIL rst_busy got=%b want=00000", {valid_o, equal_o, alarger_o, blarger_o, ready_o});
        end
        rst_ni = 1'b1; #1;
        tests++;
        if (ready_o !== 1'b1) begin fails++; $display("FAIL rst_busy_ready got=%b want=1", ready_o); end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL rst_busy_discard got=%b want=0", valid_o); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, x; int sel, k, hold; bit rb; logic s;
        for (int it = 0; it < 60; it++) begin
            a = $urandom; sel = $urandom_range(0, 4); s = $urandom_range(0, 1);
            if (sel == 4) b = a;
            else begin
                x = 32'($urandom_range(1, 255)) << (8 * sel);
                if (sel > 0) x = x | ($urandom & ((32'h1 << (8 * sel)) - 1));
                b = a ^ x;
            end
            send(a, b, s, k, rb);
            tests++;
            if (k != ref_k(a, b) || {equal_o, alarger_o, blarger_o} !== ref_flags(a, b, s) || rb) begin
                fails++; $display("FAIL rand a=%h b=%h s=%b got k=%0d f=%b rb=%b want k=%0d f=%b",
                                  a, b, s, k, {equal_o, alarger_o, blarger_o}, rb, ref_k(a, b), ref_flags(a, b, s));
            end
`ifdef CMP_MINMAX_EN
            tests++;
            if (min_o !== ref_min(a, b, s) || max_o !== ref_max(a, b, s)) begin
                fails++; $display("FAIL rand_minmax got=%h/%h want=%h/%h", min_o, max_o, ref_min(a, b, s), ref_max(a, b, s));
            end
`endif
            hold = $urandom_range(0, 2);
            repeat (hold) @(posedge clk);
            #1;
            tests++;
            if (valid_o !== 1'b1 || {equal_o, alarger_o, blarger_o} !== ref_flags(a, b, s)) begin
                fails++; $display("FAIL rand_hold got v=%b f=%b want v=1 f=%b", valid_o, {equal_o, alarger_o, blarger_o}, ref_flags(a, b, s));
            end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_directed("u_msb", 32'h8000_0000, 32'h0000_0001, 1'b0);
        test_directed("s_msb", 32'h8000_0000, 32'h0000_0001, 1'b1);
        test_directed("s_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        test_directed("s_neg", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
        test_hold();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
